// File: rtl/syscall_reader.sv
// syscall_reader: input side of the syscall path.
//   read_int (v0=5), read_string (v0=8), read_char (v0=12).
//   Consumes console bytes over rx_valid/rx_ready, holds the pipeline via
//   stall, returns a $v0 result or packs the string into 32-bit memory words.
// Optional feature: define SYSCALL_ECHO_EN to echo each accepted byte on
//   tx_data/tx_valid; without it the tx side is tied off.
module syscall_reader #(
  parameter int         ADDR_W   = 30,
  parameter logic [7:0] NL       = 8'h0A,
  parameter bit         STORE_NL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sys,
  input  logic [31:0]       regv,
  input  logic [31:0]       rega,
  input  logic [31:0]       regl,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              res_we,
  output logic [31:0]       res_data,
  output logic              stall,
  output logic              done,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  typedef enum logic [2:0] {
    S_IDLE, S_RINT, S_RSTR, S_RCHR, S_FLUSH, S_DONE
  } state_t;

  typedef enum logic [1:0] {M_INT, M_STR, M_CHR} mode_t;

  state_t            state, state_nx;
  mode_t             mode;
  logic [31:0]       acc;        // int accumulator, or the char for read_char
  logic              neg;        // read_int saw a leading '-'
  logic              seen;       // read_int has accepted at least one byte
  logic              fin;        // terminating byte accepted, wind down
  logic              wpend;      // wbuf holds a full word awaiting its write
  logic [ADDR_W-1:0] addr;       // word address of the word being packed
  logic [31:0]       left;       // characters still allowed into the buffer
  logic [31:0]       wbuf;       // word being packed, first char at [7:0]
  logic [1:0]        bcnt;       // bytes already packed into wbuf
  logic              echo_busy;  // an echoed byte has not been taken yet
  logic              start;
  logic              take;
  logic              is_digit;
  logic              unused_in;

  assign start = (state == S_IDLE) && sys &&
                 (regv == 32'd5 || regv == 32'd8 || regv == 32'd12);
  assign take     = rx_valid && rx_ready;
  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);

  // Only the low ADDR_W bits of rega matter; tx_ready matters only with echo.
  assign unused_in = ^{tx_ready, rega};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state and handshake decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_nx = state;
    rx_ready = 1'b0;
    mem_we   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (regv == 32'd5)       state_nx = S_RINT;
          else if (regv == 32'd12) state_nx = S_RCHR;
          else if (regl == 32'd0)  state_nx = S_DONE;
          else                     state_nx = S_RSTR;
        end
      end
      S_RINT, S_RCHR: begin
        if (fin) begin
          if (!echo_busy) state_nx = S_DONE;
        end else begin
          rx_ready = !echo_busy;
        end
      end
      S_RSTR: begin
        // A completed word is written before anything else happens.
        if (wpend) begin
          mem_we = 1'b1;
        end else if (fin || left == 32'd0) begin
          if (!echo_busy) state_nx = S_FLUSH;
        end else begin
          rx_ready = !echo_busy;
        end
      end
      S_FLUSH: begin
        mem_we   = 1'b1;
        state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign stall     = ((state != S_IDLE) && (state != S_DONE)) || start;
  assign done      = (state == S_DONE);
  assign res_we    = done && (mode != M_STR);
  assign res_data  = !res_we         ? 32'd0 :
                     (mode == M_INT && neg) ? 32'd0 - acc : acc;
  assign mem_addr  = mem_we ? addr : '0;
  assign mem_wdata = mem_we ? wbuf : 32'd0;

  // Operand capture, accumulation and word packing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode  <= M_INT;
      acc   <= 32'd0;
      neg   <= 1'b0;
      seen  <= 1'b0;
      fin   <= 1'b0;
      wpend <= 1'b0;
      addr  <= '0;
      left  <= 32'd0;
      wbuf  <= 32'd0;
      bcnt  <= 2'd0;
    end else if (start) begin
      mode  <= (regv == 32'd5) ? M_INT : (regv == 32'd12) ? M_CHR : M_STR;
      acc   <= 32'd0;
      neg   <= 1'b0;
      seen  <= 1'b0;
      fin   <= 1'b0;
      wpend <= 1'b0;
      addr  <= rega[ADDR_W-1:0];
      left  <= regl - 32'd1;
      wbuf  <= 32'd0;
      bcnt  <= 2'd0;
    end else begin
      if (take) begin
        unique case (state)
          S_RINT: begin
            seen <= 1'b1;
            if (rx_data == NL)            fin <= 1'b1;
            else if (is_digit)            acc <= acc * 32'd10 + {24'd0, rx_data - 8'h30};
            else if (rx_data == 8'h2D && !seen) neg <= 1'b1;
          end
          S_RCHR: begin
            acc <= {24'd0, rx_data};
            fin <= 1'b1;
          end
          S_RSTR: begin
            if (rx_data == NL) fin <= 1'b1;
            // The terminator is only taken while room remains, so storing
            // it here never overruns the buffer.
            if (rx_data != NL || STORE_NL) begin
              wbuf[{bcnt, 3'b000} +: 8] <= rx_data;
              bcnt <= bcnt + 2'd1;
              left <= left - 32'd1;
              if (bcnt == 2'd3) wpend <= 1'b1;
            end
          end
          default: ;
        endcase
      end
      // A full word just went out: move on to a fresh zeroed word.
      if (state == S_RSTR && wpend) begin
        addr  <= addr + 1'b1;
        wbuf  <= 32'd0;
        wpend <= 1'b0;
      end
    end
  end

`ifdef SYSCALL_ECHO_EN
  // Echo register: present each accepted byte until the console takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_valid <= 1'b0;
      tx_data  <= 8'd0;
    end else if (take) begin
      tx_valid <= 1'b1;
      tx_data  <= rx_data;
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end
  assign echo_busy = tx_valid;
`else
  assign tx_valid  = 1'b0;
  assign tx_data   = 8'd0;
  assign echo_busy = 1'b0;
`endif

endmodule

// File: tb/tb_syscall_reader.sv
// tb_syscall_reader: directed vector table, hand-written corner sequences and
// randomized syscalls compared against a byte-stream reference model.
module tb_syscall_reader;

  localparam int         ADDR_W   = 30;
  localparam logic [7:0] NLB      = 8'h0A;
  localparam bit         STORE_NL = 1'b1;
  localparam logic [31:0] AMASK   = 32'h3FFF_FFFF;

  typedef logic [7:0] byte_q_t[$];

  typedef struct {
    logic [31:0] v, a, l;
    string       txt;
    int          hold;
    logic [31:0] res;
    int          cons;
    int          nw;
    logic [31:0] w0, w1;
  } vec_t;

  logic              clk, rst_n, sys;
  logic [31:0]       regv, rega, regl;
  logic [7:0]        rx_data;
  logic              rx_valid, rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              res_we;
  logic [31:0]       res_data;
  logic              stall, done;
  logic [7:0]        tx_data;
  logic              tx_valid, tx_ready;

  syscall_reader dut (
    .clk(clk), .rst_n(rst_n), .sys(sys), .regv(regv), .rega(rega), .regl(regl),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .res_we(res_we), .res_data(res_data), .stall(stall), .done(done),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  byte_q_t     rxq;
  bit          exp_resw;
  logic [31:0] exp_res;
  int          exp_cons;
  logic [31:0] exp_wa[$];
  logic [31:0] exp_wd[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference model: interpret the byte stream as the syscall would.
  function automatic void model(input logic [31:0] v, input logic [31:0] a,
                                input logic [31:0] l, input byte_q_t s);
    logic [7:0]  str[$];
    logic [31:0] acc;
    bit          neg;
    int          room;
    exp_cons = 0; exp_res = 0; exp_resw = 0;
    exp_wa.delete(); exp_wd.delete();
    if (v == 32'd5) begin
      exp_resw = 1; acc = 0; neg = 0;
      foreach (s[i]) begin
        exp_cons++;
        if (s[i] == NLB) break;
        if (s[i] >= 8'h30 && s[i] <= 8'h39) acc = acc * 32'd10 + 32'(s[i] - 8'h30);
        else if (s[i] == 8'h2D && i == 0) neg = 1;
      end
      exp_res = neg ? -acc : acc;
    end else if (v == 32'd12) begin
      exp_resw = 1; exp_cons = 1; exp_res = {24'd0, s[0]};
    end else if (l != 0) begin
      room = int'(l) - 1;
      foreach (s[i]) begin
        if (str.size() == room) break;
        exp_cons++;
        if (s[i] == NLB) begin
          if (STORE_NL) str.push_back(s[i]);
          break;
        end
        str.push_back(s[i]);
      end
      str.push_back(8'h00);
      while (str.size() % 4 != 0) str.push_back(8'h00);
      for (int k = 0; k < str.size() / 4; k++) begin
        exp_wa.push_back((a + 32'(k)) & AMASK);
        exp_wd.push_back({str[4*k+3], str[4*k+2], str[4*k+1], str[4*k]});
      end
    end
  endfunction

  // Issue one syscall, feed rxq with random gaps, compare against exp_*.
  task automatic do_call(input string tag, input logic [31:0] v, input logic [31:0] a,
                         input logic [31:0] l, input int gap, input int hold);
    int          cons, res_cnt, stall_bad, proto_bad, echo_bad;
    logic [31:0] got_res;
    logic [31:0] got_wa[$];
    logic [31:0] got_wd[$];
    logic [7:0]  echo_q[$];
    bit          fin;
    cons = 0; res_cnt = 0; stall_bad = 0; proto_bad = 0; echo_bad = 0;
    got_res = 0; fin = 0;
    @(posedge clk); #1;
    sys = 1; regv = v; rega = a; regl = l; rx_valid = 0;
    @(negedge clk);
    if (!stall) stall_bad++;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      rx_valid = (rxq.size() > 0) && (cyc >= hold) && ($urandom_range(99) >= gap);
      rx_data  = (rxq.size() > 0) ? rxq[0] : 8'h00;
      sys      = ($urandom_range(7) == 0);
      regv     = 32'd5;
      rega     = $urandom;
      regl     = $urandom;
      tx_ready = 1'($urandom_range(1));
      @(negedge clk);
`ifdef SYSCALL_ECHO_EN
      if (rx_ready && tx_valid) echo_bad++;
      if (tx_valid && tx_ready) begin
        if (echo_q.size() == 0 || tx_data != echo_q[0]) echo_bad++;
        if (echo_q.size() > 0) void'(echo_q.pop_front());
      end
`else
      if (tx_valid || tx_data != 8'h00) echo_bad++;
`endif
      if (rx_valid && rx_ready) begin
        cons++;
        echo_q.push_back(rx_data);
        void'(rxq.pop_front());
      end
      if (mem_we) begin
        got_wa.push_back({2'b00, mem_addr});
        got_wd.push_back(mem_wdata);
      end
      if (mem_we && rx_ready) proto_bad++;
      if (res_we) begin res_cnt++; got_res = res_data; end
      if (done) begin
        fin = 1;
        if (stall) stall_bad++;
`ifdef SYSCALL_ECHO_EN
        if (echo_q.size() != 0 || tx_valid) echo_bad++;
`endif
      end else if (!stall) begin
        stall_bad++;
      end
      if (!fin) begin @(posedge clk); #1; end
    end
    sys = 0; rx_valid = 0;
    rxq.delete();
    check({tag, "_done"}, 32'(fin), 32'd1);
    check({tag, "_consumed"}, cons, exp_cons);
    check({tag, "_res_we"}, res_cnt, exp_resw ? 1 : 0);
    if (exp_resw) check({tag, "_res"}, got_res, exp_res);
    check({tag, "_nwrites"}, got_wa.size(), exp_wa.size());
    for (int i = 0; i < exp_wa.size() && i < got_wa.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), got_wa[i], exp_wa[i]);
      check($sformatf("%s_data%0d", tag, i), got_wd[i], exp_wd[i]);
    end
    check({tag, "_stall"}, stall_bad, 0);
    check({tag, "_rx_vs_we"}, proto_bad, 0);
    check({tag, "_echo"}, echo_bad, 0);
  endtask

  function automatic byte_q_t to_bytes(input string s);
    byte_q_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  vec_t vecs[$];

  initial begin
    int          bad, got, len, r;
    logic [31:0] v, a, l, rcap;
    byte_q_t     q;

    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          bad, got, len, r;
    logic [31:0] v, a, l, rcap;
    byte_q_t     q;

    vecs = '{
      '{32'd5,  32'h0,        32'd0, "-123\n",       0, 32'hFFFF_FF85, 5,  0, 32'h0,          32'h0},
      '{32'd8,  32'h0010_0040,32'd8, "hi\n",         0, 32'h0,         3,  1, 32'h000A_6968,  32'h0},
      '{32'd8,  32'h0000_0200,32'd5, "abcdefg\n",    0, 32'h0,         4,  2, 32'h6463_6261,  32'h0},
      '{32'd5,  32'h0,        32'd0, "\n",           0, 32'h0,         1,  0, 32'h0,          32'h0},
      '{32'd12, 32'h0,        32'd0, "z",            0, 32'h7A,        1,  0, 32'h0,          32'h0},
      '{32'd12, 32'h0,        32'd0, "A",            3, 32'h41,        1,  0, 32'h0,          32'h0},
      '{32'd8,  32'h0000_0300,32'd0, "abc\n",        0, 32'h0,         0,  0, 32'h0,          32'h0},
      '{32'd8,  32'h0000_0310,32'd1, "abc\n",        0, 32'h0,         0,  1, 32'h0,          32'h0},
      '{32'd5,  32'h0,        32'd0, "4294967297\n", 0, 32'h1,         11, 0, 32'h0,          32'h0},
      '{32'd5,  32'h0,        32'd0, "1-2x3\n",      0, 32'h7B,        6,  0, 32'h0,          32'h0},
      '{32'd8,  32'h0000_0400,32'd4, "abc\n",        0, 32'h0,         3,  1, 32'h0063_6261,  32'h0},
      '{32'd8,  32'h0000_0500,32'd5, "abc\n",        0, 32'h0,         4,  2, 32'h0A63_6261,  32'h0}
    };

    rst_n = 0; sys = 0; regv = 0; rega = 0; regl = 0;
    rx_data = 0; rx_valid = 0; tx_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs",
          {22'd0, stall, done, mem_we, res_we, rx_ready, tx_valid, tx_data == 8'h00,
           res_data == 32'd0, mem_wdata == 32'd0, mem_addr == '0},
          32'h0000_000F);
    @(negedge clk); rst_n = 1;

    // Directed vector table.
    for (int i = 0; i < vecs.size(); i++) begin
      rxq = to_bytes(vecs[i].txt);
      exp_resw = (vecs[i].v != 32'd8);
      exp_res  = vecs[i].res;
      exp_cons = vecs[i].cons;
      exp_wa.delete(); exp_wd.delete();
      if (vecs[i].nw > 0) begin exp_wa.push_back(vecs[i].a); exp_wd.push_back(vecs[i].w0); end
      if (vecs[i].nw > 1) begin exp_wa.push_back(vecs[i].a + 1); exp_wd.push_back(vecs[i].w1); end
      do_call($sformatf("vec%0d", i), vecs[i].v, vecs[i].a, vecs[i].l,
              (vecs[i].hold > 0) ? 0 : 30, vecs[i].hold);
    end

    // Unsupported code: no stall, no done.
    @(posedge clk); #1; sys = 1; regv = 32'd7;
    bad = 0;
    @(negedge clk); if (stall) bad++;
    @(posedge clk); #1; sys = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); if (stall || done || res_we || mem_we) bad++;
    end
    check("ignored_code", bad, 0);

    // Reset after two string bytes: nothing written, next call clean.
    @(posedge clk); #1; sys = 1; regv = 32'd8; rega = 32'h40; regl = 32'd20; tx_ready = 1;
    @(posedge clk); #1; sys = 0; rx_valid = 1; rx_data = 8'h61;
    got = 0;
    for (int c = 0; c < 50 && got < 2; c++) begin
      @(negedge clk); if (rx_valid && rx_ready) got++;
      @(posedge clk); #1;
      if (got == 1) rx_data = 8'h62;
    end
    check("rst_bytes_taken", got, 2);
    rx_valid = 0; rst_n = 0;
    #1;
    check("rst_midstring_outputs", {30'd0, stall, mem_we}, 32'd0);
    bad = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); if (mem_we || done || stall) bad++;
    end
    check("rst_no_write", bad, 0);
    rxq = to_bytes("Q");
    model(32'd12, 0, 0, rxq);
    do_call("rst_char", 32'd12, 0, 0, 20, 0);

`ifdef SYSCALL_ECHO_EN
    // Echo back-pressure: rx_ready must stay low while the echo waits.
    @(posedge clk); #1; sys = 1; regv = 32'd5; tx_ready = 0;
    @(posedge clk); #1; sys = 0; rx_valid = 1; rx_data = 8'h37;
    got = 0;
    for (int c = 0; c < 20 && got == 0; c++) begin
      @(negedge clk); if (rx_valid && rx_ready) got = 1;
      @(posedge clk); #1;
    end
    check("echo_first_take", got, 1);
    rx_data = NLB;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rx_ready || !tx_valid || tx_data != 8'h37 || done || !stall) bad++;
      @(posedge clk); #1;
    end
    check("echo_backpressure", bad, 0);
    tx_ready = 1;
    got = 0; rcap = 32'hDEAD_BEEF;
    for (int c = 0; c < 30 && got == 0; c++) begin
      @(negedge clk);
      if (rx_valid && rx_ready) begin @(posedge clk); #1; rx_valid = 0; @(negedge clk); end
      if (res_we) rcap = res_data;
      if (done) got = 1;
      if (got == 0) begin @(posedge clk); #1; end
    end
    rx_valid = 0;
    check("echo_done", got, 1);
    check("echo_result", rcap, 32'd7);
`endif

    // Randomized syscalls against the reference model.
    for (int t = 0; t < 40; t++) begin
      rxq.delete();
      r = $urandom_range(2);
      a = $urandom & AMASK;
      l = 0;
      if (r == 0) begin
        v = 32'd5;
        len = $urandom_range(8);
        for (int k = 0; k < len; k++) begin
          got = $urandom_range(11);
          rxq.push_back(got < 10 ? 8'(8'h30 + got) : (got == 10 ? 8'h2D : 8'h78));
        end
        rxq.push_back(NLB);
      end else if (r == 1) begin
        v = 32'd12;
        rxq.push_back(8'($urandom_range(255)));
      end else begin
        v = 32'd8;
        l = 32'($urandom_range(12));
        len = $urandom_range(12);
        for (int k = 0; k < len; k++) rxq.push_back(8'(8'h61 + $urandom_range(25)));
        rxq.push_back(NLB);
        rxq.push_back(8'h5A);
      end
      model(v, a, l, rxq);
      do_call($sformatf("rnd%0d", t), v, a, l, $urandom_range(60), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
